ex_muldiv_unit: RTL

External execution unit for RV32M multiply/divide ops issued by the core on its ex_* port.
- Accepts one request per transaction: ex_sig plus two 32-bit operands.
- Computes MUL/MULH/MULHSU/MULHU with a short fixed pipeline, and DIV/DIVU/REM/REMU with an iterative radix-2 restoring divider.
- Returns result/exception with a single-cycle valid pulse.
- Sits directly downstream of the core's ex_sig/ex_src1/ex_src2/ex_out_valid outputs; drives the core's ex_result/ex_exception/ex_in_valid inputs.

---
 rtl/ex_pkg.sv | 25 ++
 rtl/ex_divider.sv | 56 +++++
 rtl/ex_muldiv_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared op encodings, exception codes and FSM state for the RV32M multiply/divide unit.
package ex_pkg;

    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHSU = 2;
    localparam int OP_MULHU  = 3;
    localparam int OP_DIV    = 4;
    localparam int OP_DIVU   = 5;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 7;

    localparam logic [2:0] EXC_NONE    = 3'd0;
    localparam logic [2:0] EXC_ILLEGAL = 3'd1;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ex_divider.sv
// Unsigned 32-bit radix-2 restoring divider: loads on start, then one quotient bit per cycle.
// Quotient/remainder outputs show the result of the current iteration, so they are final while done=1.
module ex_divider
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_done
);

    logic [5:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;

    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    // Partial remainder shifted left with the next dividend bit, then trial-subtracted.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge       = ~w_diff[33];
    assign w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_ge};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_start) begin
            r_cnt <= 6'(DIV_ITERS);
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
        end
    end

    assign o_quotient  = w_quo_next;
    assign o_remainder = w_rem_next;
    assign o_done      = (r_cnt == 6'd1);

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execution unit: multiply in MUL_LATENCY cycles, divide in 34, illegal ops in 1, div special cases in 2.
// No backpressure: one request at a time, ex_busy tells the core to hold off until after ex_in_valid.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] ex_sig,
    input  logic [31:0] ex_src1,
    input  logic [31:0] ex_src2,
    input  logic        ex_out_valid,
    output logic [31:0] ex_result,
    output logic [2:0]  ex_exception,
    output logic        ex_in_valid,
    output logic        ex_busy
);

    localparam bit MUL_REG = (MUL_LATENCY == 2);

    state_t      r_state;
    logic [31:0] r_result;
    logic [2:0]  r_exc;
    logic        r_vld;
    logic        r_busy;
    logic [63:0] r_prod;
    logic        r_mul_hi;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic        r_div_signed;
    logic        r_is_rem;
    logic        r_setup;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_spec;

    logic [7:0]  w_op;
    logic        w_legal;
    logic        w_is_mul;
    logic        w_div_signed;
    logic        w_is_rem;
    logic        w_div0;
    logic        w_ovf;
    logic        w_mul_hi;
    logic [32:0] w_a;
    logic [32:0] w_b;
    logic [65:0] w_prod_full;
    logic [63:0] w_prod;
    logic [31:0] w_mul_word;
    logic        w_unused_sig;

    logic        w_div_start;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [31:0] w_div_quo;
    logic [31:0] w_div_rem;
    logic        w_div_done;
    logic [31:0] w_div_word;

    assign w_op         = ex_sig[7:0];
    assign w_unused_sig = ^ex_sig[19:8];
    assign w_legal      = (w_op != 8'd0) && ((w_op & (w_op - 8'd1)) == 8'd0);
    assign w_is_mul     = |w_op[OP_MULHU:OP_MUL];
    assign w_div_signed = w_op[OP_DIV] | w_op[OP_REM];
    assign w_is_rem     = w_op[OP_REM] | w_op[OP_REMU];
    assign w_div0       = (ex_src2 == 32'd0);
    assign w_ovf        = w_div_signed && (ex_src1 == 32'h8000_0000) && (ex_src2 == 32'hFFFF_FFFF);
    assign w_mul_hi     = ~w_op[OP_MUL];

    // 33-bit operands: the extra top bit is the sign for signed sources, zero otherwise.
    assign w_a         = {(w_op[OP_MULH] | w_op[OP_MULHSU]) & ex_src1[31], ex_src1};
    assign w_b         = {w_op[OP_MULH] & ex_src2[31], ex_src2};
    assign w_prod_full = $signed({{33{w_a[32]}}, w_a}) * $signed({{33{w_b[32]}}, w_b});
    assign w_prod      = w_prod_full[63:0];
    assign w_mul_word  = w_mul_hi ? w_prod[63:32] : w_prod[31:0];

    assign w_div_start = (r_state == ST_DIV) && r_setup;
    assign w_abs1      = (r_div_signed && r_src1[31]) ? (~r_src1 + 32'd1) : r_src1;
    assign w_abs2      = (r_div_signed && r_src2[31]) ? (~r_src2 + 32'd1) : r_src2;

    ex_divider u_divider (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (w_div_start),
        .i_dividend  (w_abs1),
        .i_divisor   (w_abs2),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem),
        .o_done      (w_div_done)
    );

    assign w_div_word = r_is_rem ? (r_neg_r ? (~w_div_rem + 32'd1) : w_div_rem)
                                 : (r_neg_q ? (~w_div_quo + 32'd1) : w_div_quo);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_result     <= '0;
            r_exc        <= EXC_NONE;
            r_vld        <= 1'b0;
            r_busy       <= 1'b0;
            r_prod       <= '0;
            r_mul_hi     <= 1'b0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_div_signed <= 1'b0;
            r_is_rem     <= 1'b0;
            r_setup      <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_spec       <= '0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ex_out_valid) begin
                        r_busy <= 1'b1;
                        if (!w_legal) begin
                            r_result <= '0;
                            r_exc    <= EXC_ILLEGAL;
                            r_vld    <= 1'b1;
                            r_state  <= ST_RESP;
                        end else if (w_is_mul) begin
                            if (MUL_REG) begin
                                r_prod   <= w_prod;
                                r_mul_hi <= w_mul_hi;
                                r_state  <= ST_MUL;
                            end else begin
                                r_result <= w_mul_word;
                                r_exc    <= EXC_NONE;
                                r_vld    <= 1'b1;
                                r_state  <= ST_RESP;
                            end
                        end else if (w_div0) begin
                            r_spec  <= w_is_rem ? ex_src1 : 32'hFFFF_FFFF;
                            r_state <= ST_RESP;
                        end else if (w_ovf) begin
                            r_spec  <= w_is_rem ? 32'd0 : 32'h8000_0000;
                            r_state <= ST_RESP;
                        end else begin
                            r_src1       <= ex_src1;
                            r_src2       <= ex_src2;
                            r_div_signed <= w_div_signed;
                            r_is_rem     <= w_is_rem;
                            r_setup      <= 1'b1;
                            r_state      <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    r_result <= r_mul_hi ? r_prod[63:32] : r_prod[31:0];
                    r_exc    <= EXC_NONE;
                    r_vld    <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_DIV: begin
                    r_setup <= 1'b0;
                    if (r_setup) begin
                        r_neg_q <= r_div_signed & (r_src1[31] ^ r_src2[31]);
                        r_neg_r <= r_div_signed & r_src1[31];
                    end else if (w_div_done) begin
                        r_result <= w_div_word;
                        r_exc    <= EXC_NONE;
                        r_vld    <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Entered with r_vld already set for normal ops; special divides pulse one cycle later.
                    if (r_vld) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_result <= r_spec;
                        r_exc    <= EXC_NONE;
                        r_vld    <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ex_result    = r_result;
    assign ex_exception = r_exc;
    assign ex_in_valid  = r_vld;
    assign ex_busy      = r_busy;

endmodule
